// File: rtl/k_means_iteration_ctrl_if.sv
// Datapath-side handshake between the iteration controller and the
// pass engine / aggregation / divider path.
interface k_means_iteration_ctrl_if;
    logic pass_start;
    logic pass_done;
    logic sse_valid;
    logic sse_converge;
    logic upd_valid;
    logic upd_last;

    modport master (
        output pass_start,
        input  pass_done,
        input  sse_valid,
        input  sse_converge,
        input  upd_valid,
        input  upd_last
    );

    modport slave (
        input  pass_start,
        output pass_done,
        output sse_valid,
        output sse_converge,
        output upd_valid,
        output upd_last
    );
endinterface

// File: rtl/k_means_iteration_ctrl.sv
// Lloyd-iteration sequencer for the k-means operator: launches data passes,
// collects SSE and centroid-update results, and decides when to stop.
module k_means_iteration_ctrl #(
    parameter int MAX_DEPTH_BITS   = 9,
    parameter int NUM_CLUSTER_BITS = 3,
    parameter int ITER_BITS        = 16,
    parameter int TIMEOUT_BITS     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_operator,
    input  logic [MAX_DEPTH_BITS:0]     data_dim,
    input  logic [NUM_CLUSTER_BITS:0]   num_cluster,
    input  logic [ITER_BITS-1:0]        max_iter,
    input  logic [TIMEOUT_BITS-1:0]     timeout_limit,
    k_means_iteration_ctrl_if.master    dp,
    output logic                        busy,
    output logic                        done,
    output logic [ITER_BITS-1:0]        iter_cnt,
    output logic                        converged,
    output logic                        err_cfg,
    output logic                        err_upd,
    output logic                        err_timeout
);

    localparam int BEAT_W = MAX_DEPTH_BITS + NUM_CLUSTER_BITS + 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS     = 3'd1,
        WAIT_RES = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                   state_reg;
    logic                     pass_start_reg;
    logic [ITER_BITS-1:0]     max_iter_reg;
    logic [TIMEOUT_BITS-1:0]  timeout_reg;
    logic [TIMEOUT_BITS-1:0]  wd_cnt_reg;
    logic [BEAT_W-1:0]        exp_beats_reg;
    logic [BEAT_W-1:0]        beat_cnt_reg;
    logic                     sse_seen_reg;
    logic                     upd_seen_reg;

    logic [BEAT_W-1:0]        beat_inc;
    logic [TIMEOUT_BITS-1:0]  wd_inc;
    logic                     wd_event;
    logic                     wd_expire;
    logic                     results_done;

    assign dp.pass_start = pass_start_reg;
    assign beat_inc      = beat_cnt_reg + BEAT_W'(1);
    assign wd_inc        = wd_cnt_reg + TIMEOUT_BITS'(1);
    assign wd_event      = dp.pass_done | dp.sse_valid | dp.upd_valid;
    assign results_done  = sse_seen_reg & upd_seen_reg;

    // wd_inc is the idle count including the current cycle.
    assign wd_expire = (timeout_reg != '0) && !wd_event &&
                       (wd_inc >= timeout_reg - TIMEOUT_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pass_start_reg <= 1'b0;
            max_iter_reg   <= '0;
            timeout_reg    <= '0;
            wd_cnt_reg     <= '0;
            exp_beats_reg  <= '0;
            beat_cnt_reg   <= '0;
            sse_seen_reg   <= 1'b0;
            upd_seen_reg   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            iter_cnt       <= '0;
            converged      <= 1'b0;
            err_cfg        <= 1'b0;
            err_upd        <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            pass_start_reg <= 1'b0;
            done           <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_operator) begin
                        iter_cnt     <= '0;
                        converged    <= 1'b0;
                        err_cfg      <= 1'b0;
                        err_upd      <= 1'b0;
                        err_timeout  <= 1'b0;
                        busy         <= 1'b1;
                        sse_seen_reg <= 1'b0;
                        upd_seen_reg <= 1'b0;
                        beat_cnt_reg <= '0;
                        wd_cnt_reg   <= '0;
                        if (data_dim == '0 || num_cluster == '0) begin
                            err_cfg   <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            max_iter_reg   <= (max_iter == '0) ? ITER_BITS'(1) : max_iter;
                            timeout_reg    <= timeout_limit;
                            exp_beats_reg  <= BEAT_W'(data_dim) * BEAT_W'(num_cluster);
                            pass_start_reg <= 1'b1;
                            state_reg      <= PASS;
                        end
                    end
                end

                PASS, WAIT_RES: begin
                    if (dp.sse_valid) begin
                        if (sse_seen_reg) err_upd <= 1'b1;
                        else              sse_seen_reg <= 1'b1;
                    end
                    if (dp.upd_valid) begin
                        if (upd_seen_reg) begin
                            err_upd <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_inc;
                            if (dp.upd_last) begin
                                upd_seen_reg <= 1'b1;
                                if (beat_cnt_reg != exp_beats_reg - BEAT_W'(1))
                                    err_upd <= 1'b1;
                            end else if (beat_inc == exp_beats_reg) begin
                                // Stream overran without a last marker; close it out.
                                upd_seen_reg <= 1'b1;
                                err_upd      <= 1'b1;
                            end
                        end
                    end
                    wd_cnt_reg <= wd_event ? '0 : wd_inc;
                    if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state_reg   <= DONE;
                    end else if (state_reg == PASS) begin
                        // Results already registered means sse_converge has settled.
                        if (dp.pass_done)
                            state_reg <= results_done ? CHECK : WAIT_RES;
                    end else if (results_done) begin
                        state_reg <= CHECK;
                    end
                end

                CHECK: begin
                    iter_cnt <= iter_cnt + ITER_BITS'(1);
                    if (dp.sse_converge) begin
                        converged <= 1'b1;
                        state_reg <= DONE;
                    end else if (iter_cnt + ITER_BITS'(1) >= max_iter_reg) begin
                        state_reg <= DONE;
                    end else begin
                        sse_seen_reg   <= 1'b0;
                        upd_seen_reg   <= 1'b0;
                        beat_cnt_reg   <= '0;
                        wd_cnt_reg     <= '0;
                        pass_start_reg <= 1'b1;
                        state_reg      <= PASS;
                    end
                end

                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_k_means_iteration_ctrl.sv
// Scenario bench for k_means_iteration_ctrl: each task runs one operator job,
// a scoreboard queue holds the expected run outcome until done arrives.
module tb_k_means_iteration_ctrl;

    typedef struct packed {
        logic [15:0] iters;
        logic        conv;
        logic        ecfg;
        logic        eupd;
        logic        eto;
        logic [7:0]  passes;
        logic        busy_at_done;
        logic        done_after;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_operator = 1'b0;
    logic [9:0]  data_dim = '0;
    logic [3:0]  num_cluster = '0;
    logic [15:0] max_iter = '0;
    logic [31:0] timeout_limit = '0;
    logic        busy, done, converged, err_cfg, err_upd, err_timeout;
    logic [15:0] iter_cnt;

    k_means_iteration_ctrl_if dp_if ();

    k_means_iteration_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_operator (start_operator),
        .data_dim       (data_dim),
        .num_cluster    (num_cluster),
        .max_iter       (max_iter),
        .timeout_limit  (timeout_limit),
        .dp             (dp_if.master),
        .busy           (busy),
        .done           (done),
        .iter_cnt       (iter_cnt),
        .converged      (converged),
        .err_cfg        (err_cfg),
        .err_upd        (err_upd),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   pass_total = 0;
    int   checks = 0;
    int   errors = 0;
    int   run_base, start_cyc, ps_cyc, pd_cyc, done_cyc;
    res_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dp_if.pass_start === 1'b1) begin
            pass_total <= pass_total + 1;
            $display("pass_start at cycle %0d", cyc);
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at 2ms, required completion");
        $fatal(1, "global timeout");
    end

    function automatic string fmt(input res_t r);
        return $sformatf("iters=%0d conv=%0b cfg=%0b upd=%0b to=%0b passes=%0d busy@done=%0b done+1=%0b",
                         r.iters, r.conv, r.ecfg, r.eupd, r.eto, r.passes, r.busy_at_done, r.done_after);
    endfunction

    function automatic res_t mk(input int it, input bit cv, input bit ec, input bit eu,
                                input bit et, input int np);
        res_t r;
        r = '0;
        r.iters  = 16'(it);
        r.conv   = cv;
        r.ecfg   = ec;
        r.eupd   = eu;
        r.eto    = et;
        r.passes = 8'(np);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Config inputs are scrambled after the start to show they were latched.
    task automatic start_run(input logic [9:0] d, input logic [3:0] k,
                             input logic [15:0] mi, input logic [31:0] to);
        data_dim = d; num_cluster = k; max_iter = mi; timeout_limit = to;
        start_operator = 1'b1;
        start_cyc = cyc;
        run_base  = pass_total;
        tick();
        start_operator = 1'b0;
        data_dim = '0; num_cluster = '0; max_iter = 16'd7; timeout_limit = 32'd3;
    endtask

    task automatic wait_pass_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (dp_if.pass_start === 1'b1) begin
                ok = 1'b1;
                ps_cyc = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pass_start_wait: got no pulse in 300 cycles, required a pulse");
        end
    endtask

    task automatic serve(input int gap, input int nbeats, input int last_at,
                         input bit conv, input bit early);
        if (!early) begin
            repeat (gap) tick();
            dp_if.pass_done = 1'b1; pd_cyc = cyc; tick(); dp_if.pass_done = 1'b0;
            for (int i = 1; i <= nbeats; i++) begin
                dp_if.upd_valid = 1'b1; dp_if.upd_last = (i == last_at); tick();
            end
            dp_if.upd_valid = 1'b0; dp_if.upd_last = 1'b0;
            dp_if.sse_valid = 1'b1; dp_if.sse_converge = conv; tick();
            dp_if.sse_valid = 1'b0;
        end else begin
            for (int i = 1; i <= nbeats; i++) begin
                dp_if.upd_valid = 1'b1; dp_if.upd_last = (i == last_at);
                if (i == nbeats) begin
                    dp_if.sse_valid = 1'b1; dp_if.sse_converge = conv;
                end
                tick();
            end
            dp_if.upd_valid = 1'b0; dp_if.upd_last = 1'b0; dp_if.sse_valid = 1'b0;
            repeat (gap) tick();
            dp_if.pass_done = 1'b1; pd_cyc = cyc; tick(); dp_if.pass_done = 1'b0;
        end
    endtask

    task automatic collect(input string name, output res_t got);
        bit seen = 1'b0;
        got = '0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            got.passes = 8'hff;
            $display("FAIL %s done_wait: got no done in 2000 cycles, required a pulse", name);
        end else begin
            done_cyc         = cyc;
            got.iters        = iter_cnt;
            got.conv         = converged;
            got.ecfg         = err_cfg;
            got.eupd         = err_upd;
            got.eto          = err_timeout;
            got.passes       = 8'(pass_total - run_base);
            got.busy_at_done = busy;
            tick();
            got.done_after   = done;
        end
        $display("run %s: done at cycle %0d, %s", name, done_cyc, fmt(got));
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, iter_cnt, converged, err_cfg, err_upd, err_timeout, dp_if.pass_start} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {busy, done, iter_cnt, converged, err_cfg, err_upd, err_timeout, dp_if.pass_start});
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, dp_if.pass_start} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got busy/done/pass_start=%b, required 000",
                     {busy, done, dp_if.pass_start});
        end
    endtask

    task automatic test_iter_limit();
        res_t got, e;
        bit ok;
        sb.push_back(mk(3, 0, 0, 0, 0, 3));
        start_run(10'd4, 4'd2, 16'd3, 32'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1", busy);
        end
        for (int it = 0; it < 3; it++) begin
            wait_pass_start(ok);
            if (!ok) break;
            serve(50, 8, 8, 1'b0, 1'b0);
        end
        collect("iter_limit", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL iter_limit: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_converge();
        res_t got, e;
        bit ok;
        sb.push_back(mk(2, 1, 0, 0, 0, 2));
        start_run(10'd4, 4'd2, 16'd3, 32'd0);
        for (int it = 0; it < 2; it++) begin
            wait_pass_start(ok);
            if (!ok) break;
            serve(50, 8, 8, (it == 1), 1'b0);
        end
        collect("converge", got);
        dp_if.sse_converge = 1'b0;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL converge: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_early_results();
        res_t got, e;
        bit ok;
        sb.push_back(mk(2, 0, 0, 0, 0, 2));
        start_run(10'd4, 4'd2, 16'd2, 32'd0);
        wait_pass_start(ok);
        if (ok) begin
            serve(5, 8, 8, 1'b0, 1'b1);
            wait_pass_start(ok);
            checks++;
            if (ps_cyc !== pd_cyc + 2) begin
                errors++;
                $display("FAIL early_latency: got pass_start %0d cycles after pass_done, required 2",
                         ps_cyc - pd_cyc);
            end
            if (ok) serve(20, 8, 8, 1'b0, 1'b0);
        end
        collect("early_results", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL early_results: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_upd_error();
        res_t got, e;
        bit ok;
        sb.push_back(mk(1, 0, 0, 1, 0, 1));
        start_run(10'd4, 4'd2, 16'd1, 32'd0);
        wait_pass_start(ok);
        if (ok) serve(10, 6, 6, 1'b0, 1'b0);
        collect("upd_short", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL upd_short: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_timeout();
        res_t got, e;
        bit ok;
        sb.push_back(mk(0, 0, 0, 0, 1, 1));
        start_run(10'd4, 4'd2, 16'd3, 32'd100);
        wait_pass_start(ok);
        collect("timeout", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL timeout: got %s, required %s", fmt(got), fmt(e));
        end
        checks++;
        if (done_cyc !== ps_cyc + 100) begin
            errors++;
            $display("FAIL timeout_latency: got done %0d cycles after pass_start, required 100",
                     done_cyc - ps_cyc);
        end
    endtask

    task automatic test_cfg_error();
        res_t got, e;
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        start_run(10'd0, 4'd2, 16'd3, 32'd0);
        collect("cfg_dim0", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL cfg_dim0: got %s, required %s", fmt(got), fmt(e));
        end
        checks++;
        if (done_cyc !== start_cyc + 2) begin
            errors++;
            $display("FAIL cfg_latency: got done %0d cycles after start, required 2",
                     done_cyc - start_cyc);
        end
    endtask

    task automatic test_back_to_back();
        res_t got, e;
        bit ok;
        sb.push_back(mk(2, 0, 0, 0, 0, 2));
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        start_run(10'd5, 4'd3, 16'd2, 32'd0);
        for (int it = 0; it < 2; it++) begin
            wait_pass_start(ok);
            if (!ok) break;
            if (it == 0) begin
                data_dim = '0; start_operator = 1'b1; tick(); start_operator = 1'b0;
            end
            serve(20, 15, 15, 1'b0, 1'b0);
        end
        collect("e15_busy_start", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL e15_busy_start: got %s, required %s", fmt(got), fmt(e));
        end
        start_run(10'd4, 4'd0, 16'd1, 32'd0);
        collect("cfg_k0", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL cfg_k0: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_reset_midrun();
        res_t got, e;
        bit ok;
        start_run(10'd4, 4'd2, 16'd3, 32'd0);
        wait_pass_start(ok);
        dp_if.sse_valid = 1'b1; tick(); tick(); dp_if.sse_valid = 1'b0;
        repeat (10) tick();
        dp_if.pass_done = 1'b1; tick(); dp_if.pass_done = 1'b0; tick();
        checks++;
        if ({busy, err_upd} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_state: got busy/err_upd=%b, required 11", {busy, err_upd});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, err_upd, iter_cnt, dp_if.pass_start} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got busy/err_upd/iter_cnt/pass_start=%h, required 0",
                     {busy, err_upd, iter_cnt, dp_if.pass_start});
        end
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back(mk(1, 0, 0, 0, 0, 1));
        start_run(10'd4, 4'd2, 16'd0, 32'd0);
        wait_pass_start(ok);
        if (ok) serve(10, 8, 8, 1'b0, 1'b0);
        collect("after_reset_max0", got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL after_reset_max0: got %s, required %s", fmt(got), fmt(e));
        end
    endtask

    initial begin
        dp_if.pass_done    = 1'b0;
        dp_if.sse_valid    = 1'b0;
        dp_if.sse_converge = 1'b0;
        dp_if.upd_valid    = 1'b0;
        dp_if.upd_last     = 1'b0;
        test_reset();
        test_iter_limit();
        test_converge();
        test_early_results();
        test_upd_error();
        test_timeout();
        test_cfg_error();
        test_back_to_back();
        test_reset_midrun();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/k_means_iteration_ctrl.md
Name: k_means_iteration_ctrl

Overview:
- Sequences Lloyd iterations of the k-means operator.
- Launches each data pass, then waits for two results from the aggregation/divider path: the per-pass SSE and the full centroid update stream.
- After each pass, decides whether to run another iteration or stop (convergence, iteration limit, timeout).
- Sits between the host start/config registers and the pass engine plus aggregation/divider datapath; reports status and error flags to the host.

Parameters:
- MAX_DEPTH_BITS, 9, dimension field width minus 1.
- NUM_CLUSTER_BITS, 3, cluster-count field width minus 1.
- ITER_BITS, 16, width of iteration limit and counter.
- TIMEOUT_BITS, 32, width of watchdog limit and counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_operator  in  1  one-cycle start request
- data_dim  in  MAX_DEPTH_BITS+1  dimensions per point
- num_cluster  in  NUM_CLUSTER_BITS+1  number of clusters
- max_iter  in  ITER_BITS  iteration limit; 0 treated as 1
- timeout_limit  in  TIMEOUT_BITS  idle-cycle watchdog limit; 0 disables
- pass_start  out  1  one-cycle pulse launching a data pass
- pass_done  in  1  one-cycle pulse: pass engine finished streaming
- sse_valid  in  1  aggregation SSE result strobe
- sse_converge  in  1  aggregation convergence level; valid from the cycle after sse_valid
- upd_valid  in  1  divider centroid-beat strobe
- upd_last  in  1  last centroid beat of the update
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle completion pulse
- iter_cnt  out  ITER_BITS  completed iterations
- converged  out  1  run ended on convergence
- err_cfg, err_upd, err_timeout  out  1 each  sticky error flags

Behaviour:
- Reset (async assert, synchronous-release usage): state IDLE; all outputs 0; internal counters and flags 0.
- States: IDLE, PASS, WAIT_RES, CHECK, DONE.
- IDLE:
  - start_operator clears iter_cnt, converged and all err flags, and sets busy.
  - If data_dim==0 or num_cluster==0: set err_cfg and go to DONE.
  - Otherwise: latch data_dim, num_cluster, max_iter and timeout_limit; expected beats E = num_cluster*data_dim (full-width product, no truncation); go to PASS.
- PASS:
  - pass_start is high on the first cycle in PASS only.
  - On pass_done go to WAIT_RES.
  - Results may arrive before pass_done. sse_valid and upd_valid are captured in PASS as well as WAIT_RES.
- WAIT_RES:
  - Wait until sse_seen and upd_seen are both set. Either order is legal; both strobes in the same cycle are legal.
  - Go to CHECK on the cycle after the second flag is set, so sse_converge has settled.
- Update beat checking:
  - Count upd_valid beats.
  - If upd_last arrives with count != E-1, or the count reaches E without upd_last: set err_upd and treat the update as complete (upd_seen=1).
  - Beats arriving after upd_seen are ignored, and err_upd is set.
- A second sse_valid within one iteration is ignored, and err_upd is set.
- CHECK (exactly one cycle):
  - iter_cnt += 1.
  - If sse_converge: set converged, go to DONE.
  - Else if iter_cnt+1 >= effective max_iter: go to DONE.
  - Else clear sse_seen, upd_seen and the beat counter, and go to PASS.
- DONE: done=1 for one cycle; busy drops in the same cycle; return to IDLE. Flags and iter_cnt hold until the next start.
- Watchdog:
  - In PASS and WAIT_RES, the counter increments each cycle and resets on pass_done, sse_valid or upd_valid.
  - When timeout_limit != 0 and counter == timeout_limit-1: set err_timeout and go to DONE. iter_cnt is not incremented.
- start_operator while busy is ignored. Config inputs are sampled only at the accepted start.
- Iteration-limit latency: pass_start for iteration n+1 occurs exactly 2 cycles after the cycle both results are seen (CHECK, then PASS).
- Reset mid-operation: returns immediately to IDLE; any in-flight results are dropped.

Test Plan:
- dim=4, k=2, max_iter=3, sse_converge=0, pass_done 50 cycles after each pass_start, 8 upd beats with last on the 8th, then sse_valid -> 3 pass_start pulses, done once, iter_cnt=3, converged=0, no errors.
- Same config; sse_converge=1 after iteration 2 -> 2 pass_start pulses, iter_cnt=2, converged=1.
- sse_valid and final upd beat in the same cycle, both before pass_done -> CHECK 1 cycle after pass_done; next pass_start 2 cycles after pass_done.
- upd_last on beat 6 of E=8 -> err_upd=1, iteration still completes, iter_cnt advances.
- timeout_limit=100, pass_done never asserted -> err_timeout=1 and done 100 cycles after pass_start, iter_cnt=0; data_dim=0 start -> err_cfg=1, done 2 cycles after start, no pass_start.
- rst_n asserted during WAIT_RES -> busy=0 immediately; new start runs cleanly with flags cleared; max_iter=0 -> exactly 1 pass.
